// File: rtl/echo_pkg.sv
// Shared types and defaults for the echo delay-line sequencer.
// Optional build macro: ECHO_OVERRUN_CNT_EN.
package echo_pkg;

    localparam int ECHO_DATA_W = 16;
    localparam int ECHO_ADDR_W = 12;
    localparam int SEQ_LATENCY = 4;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } echo_seq_state_t;

endpackage

// File: rtl/echo_delay_sequencer_if.sv
// Delay-line RAM port bundle: the sequencer is master, the RAM is slave.
// Optional build macro: ECHO_OVERRUN_CNT_EN (not used here).
interface echo_delay_sequencer_if
    import echo_pkg::*;
#(
    parameter int DATA_W = ECHO_DATA_W,
    parameter int ADDR_W = ECHO_ADDR_W
);

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output ram_addr,
        output ram_we,
        output ram_din,
        input  ram_dout
    );

    modport slave (
        input  ram_addr,
        input  ram_we,
        input  ram_din,
        output ram_dout
    );

endinterface

// File: rtl/echo_ptr_ring.sv
// Circular write pointer, saturating fill count and delayed read address.
// Optional build macro: ECHO_OVERRUN_CNT_EN (not used here).
module echo_ptr_ring
    import echo_pkg::*;
#(
    parameter int ADDR_W = ECHO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] filled
);

    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] fill;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp   <= '0;
            fill <= '0;
        end else if (advance) begin
            wp <= wp + 1'b1;
            if (fill != '1) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Modulo-depth subtraction; d at max lands on wp+1.
    assign rd_addr = wp - d;
    assign wr_addr = wp;
    assign filled  = fill;

endmodule

// File: rtl/echo_delay_sequencer.sv
// Read-then-write sequencer for the echo delay-line RAM.
// Optional build macro: ECHO_OVERRUN_CNT_EN adds overrun_cnt.
module echo_delay_sequencer
    import echo_pkg::*;
#(
    parameter int DATA_W = ECHO_DATA_W,
    parameter int ADDR_W = ECHO_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_sample_ready,
    input  logic [DATA_W-1:0]      sample_in,
    input  logic [ADDR_W-1:0]      delay_len,
    echo_delay_sequencer_if.master ram,
    output logic [DATA_W-1:0]      echoed_sample,
    output logic                   echoed_valid,
`ifdef ECHO_OVERRUN_CNT_EN
    output logic [7:0]             overrun_cnt,
`endif
    output logic                   busy
);

    echo_seq_state_t state;

    logic              nsr_d;
    logic              evt;
    logic [DATA_W-1:0] s;
    logic [ADDR_W-1:0] d;
    logic [DATA_W-1:0] e_next;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] filled;
    logic              advance;

    assign evt     = new_sample_ready & ~nsr_d;
    assign advance = (state == DONE);
    assign busy    = (state != IDLE);

    echo_ptr_ring #(
        .ADDR_W (ADDR_W)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .d       (d),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .filled  (filled)
    );

    // Unwritten slots read as silence; zero delay bypasses the RAM.
    always_comb begin
        e_next = ram.ram_dout;
        if (d == '0) begin
            e_next = s;
        end else if (filled < d) begin
            e_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            nsr_d         <= 1'b0;
            s             <= '0;
            d             <= '0;
            echoed_sample <= '0;
            echoed_valid  <= 1'b0;
        end else begin
            nsr_d        <= new_sample_ready;
            echoed_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (evt) begin
                        s     <= sample_in;
                        d     <= delay_len;
                        state <= READ;
                    end
                end
                READ:  state <= WAIT;
                WAIT:  state <= WRITE;
                WRITE: begin
                    echoed_sample <= e_next;
                    echoed_valid  <= 1'b1;
                    state         <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram.ram_addr = '0;
        ram.ram_we   = 1'b0;
        ram.ram_din  = '0;
        unique case (1'b1)
            (state == READ),
            (state == WAIT): begin
                ram.ram_addr = rd_addr;
            end
            (state == WRITE): begin
                ram.ram_addr = wr_addr;
                ram.ram_we   = 1'b1;
                ram.ram_din  = s;
            end
            default: begin
                ram.ram_addr = '0;
            end
        endcase
    end

`ifdef ECHO_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt <= '0;
        end else if (evt && busy && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule
